// File: rtl/fb_pipereg_pkg.sv
// Shared constants for the fb_pipereg pipeline register: state encodings
// and default field widths.
package fb_pipereg_pkg;

  localparam int FB_32BITS = 32;
  localparam int FB_CTRL_W = 19;
  localparam int FB_DATA_W = 4 * FB_32BITS;

  // The encoding equals the number of held entries, so occ is the state itself.
  localparam logic [1:0] FB_PIPE_EMPTY = 2'd0;
  localparam logic [1:0] FB_PIPE_ONE   = 2'd1;
  localparam logic [1:0] FB_PIPE_TWO   = 2'd2;

endpackage

// File: rtl/fb_pipereg_slot.sv
// One storage entry (ctrl + data). Flush clears only ctrl. Lock turns a load
// into a bubble: ctrl is zeroed and data is kept.
module fb_pipereg_slot
  import fb_pipereg_pkg::*;
#(
  parameter int CTRL_W = FB_CTRL_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              lock,
  input  logic              flush,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // Entry register: reset clears everything, flush outranks load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (flush) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= lock ? '0 : d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/fb_pipereg.sv
// Pipeline register with optional two-entry skid buffer. The head slot always
// drives the output and the skid slot catches one beat under backpressure.
// With SKID=0, in_ready follows out_ready combinationally, so the skid slot
// never loads.
module fb_pipereg
  import fb_pipereg_pkg::*;
#(
  parameter int CTRL_W = FB_CTRL_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lock,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic [1:0]        state, state_nxt;
  logic              in_fire, out_fire;
  logic              head_load, skid_load, head_from_skid;
  logic [CTRL_W-1:0] skid_ctrl, head_d_ctrl;
  logic [DATA_W-1:0] skid_data, head_d_data;

  assign out_valid = (state != FB_PIPE_EMPTY);
  assign occ       = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: decoded from state only, which breaks the out_ready path.
      assign in_ready = (state != FB_PIPE_TWO);
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Next-state and slot load decode. Flush forces EMPTY, and the slots zero ctrl themselves.
  always_comb begin
    state_nxt      = state;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    case (state)
      FB_PIPE_EMPTY: begin
        if (in_fire) begin
          state_nxt = FB_PIPE_ONE;
          head_load = 1'b1;
        end
      end
      FB_PIPE_ONE: begin
        if (in_fire && !out_fire) begin
          state_nxt = FB_PIPE_TWO;
          skid_load = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_nxt = FB_PIPE_EMPTY;
        end else if (in_fire && out_fire) begin
          head_load = 1'b1;
        end
      end
      FB_PIPE_TWO: begin
        if (out_fire) begin
          state_nxt      = FB_PIPE_ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_nxt = FB_PIPE_EMPTY;
    endcase
    if (flush) state_nxt = FB_PIPE_EMPTY;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FB_PIPE_EMPTY;
    else      state <= state_nxt;
  end

  // The skid entry already had lock applied when it was captured, so lock
  // must not touch the skid-to-head move.
  assign head_d_ctrl = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_d_data = head_from_skid ? skid_data : in_data;

  fb_pipereg_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk    (clk),
    .rst    (rst),
    .load   (head_load),
    .lock   (lock & ~head_from_skid),
    .flush  (flush),
    .d_ctrl (head_d_ctrl),
    .d_data (head_d_data),
    .q_ctrl (out_ctrl),
    .q_data (out_data)
  );

  fb_pipereg_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .lock   (lock),
    .flush  (flush),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

endmodule

// File: tb/tb_fb_pipereg.sv
// Bench for fb_pipereg: a SKID=1 instance for directed cases and streaming,
// plus a SKID=0 instance for streaming. Accepted beats are queued as expected
// output, and a negedge monitor pops and compares each delivered beat.
module tb_fb_pipereg;
  localparam int CW = 19;
  localparam int DW = 128;
  typedef logic [CW+DW-1:0] beat_t;

  logic clk, rst;
  logic          flush1, lock1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [CW-1:0] in_ctrl1, out_ctrl1;
  logic [DW-1:0] in_data1, out_data1;
  logic [1:0]    occ1;
  logic          flush0, lock0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [CW-1:0] in_ctrl0, out_ctrl0;
  logic [DW-1:0] in_data0, out_data0;
  logic [1:0]    occ0;

  int    pass_cnt = 0, tot_cnt = 0;
  int    dlv0 = 0, dlv1 = 0;
  logic [1:0] occ0_max = 2'd0;
  bit    done0, done1;
  beat_t q1[$], q0[$];

  fb_pipereg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .lock(lock1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .occ(occ1));

  fb_pipereg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .lock(lock0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occ(occ0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: checks delivered beats first, then applies flush or queues accepted beats.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (out_valid1 && out_ready1) begin
        dlv1++;
        if (q1.size() == 0) begin
          tot_cnt++;
          $display("FAIL sb1_underflow: beat %0h with no expected entry", {out_ctrl1, out_data1});
        end else begin
          e = q1.pop_front();
          chk("sb1_beat", {out_ctrl1, out_data1}, e);
        end
      end
      if (flush1) q1.delete();
      else if (in_valid1 && in_ready1) q1.push_back({(lock1 ? {CW{1'b0}} : in_ctrl1), in_data1});

      if (occ0 > occ0_max) occ0_max = occ0;
      if (out_valid0 && out_ready0) begin
        dlv0++;
        if (q0.size() == 0) begin
          tot_cnt++;
          $display("FAIL sb0_underflow: beat %0h with no expected entry", {out_ctrl0, out_data0});
        end else begin
          e = q0.pop_front();
          chk("sb0_beat", {out_ctrl0, out_data0}, e);
        end
      end
      if (flush0) q0.delete();
      else if (in_valid0 && in_ready0) q0.push_back({(lock0 ? {CW{1'b0}} : in_ctrl0), in_data0});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    {flush1, lock1, in_valid1, out_ready1} = '0;
    {flush0, lock0, in_valid0, out_ready0} = '0;
    in_ctrl1 = '0; in_data1 = '0; in_ctrl0 = '0; in_data0 = '0;
    #1;
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_occ", occ1, 0);
    chk("rst_in_ready", in_ready1, 1);
    chk("rst_out_ctrl", out_ctrl1, 0);
    chk("rst_out_data", out_data1, 0);
    chk("rst_in_ready_skid0", in_ready0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // Backpressure: 0x1 and 0x2 fill both entries, 0x3 waits upstream.
    in_valid1 = 1; in_ctrl1 = 19'h1; in_data1 = 128'h101; cyc();
    chk("bp_occ1", occ1, 1);
    in_ctrl1 = 19'h2; in_data1 = 128'h102; cyc();
    in_ctrl1 = 19'h3; in_data1 = 128'h103; cyc();
    chk("bp_occ2", occ1, 2);
    chk("bp_in_ready", in_ready1, 0);
    chk("bp_head", out_ctrl1, 19'h1);
    out_ready1 = 1; cyc();
    cyc();
    in_valid1 = 0; cyc();
    chk("bp_drained", occ1, 0);

    // Bubble: lock on an accepted beat zeroes ctrl and keeps data.
    out_ready1 = 0; lock1 = 1; in_valid1 = 1; in_ctrl1 = 19'h7FFFF; in_data1 = 128'hAB; cyc();
    in_valid1 = 0;
    chk("bub_valid", out_valid1, 1);
    chk("bub_ctrl", out_ctrl1, 0);
    chk("bub_data", out_data1, 128'hAB);
    cyc();
    chk("lock_idle_occ", occ1, 1);
    lock1 = 0; out_ready1 = 1; cyc();
    chk("bub_drained", occ1, 0);

    // Flush race from TWO: head delivered, skid and input beat discarded.
    out_ready1 = 0; in_valid1 = 1;
    in_ctrl1 = 19'h11; in_data1 = 128'h211; cyc();
    in_ctrl1 = 19'h12; in_data1 = 128'h212; cyc();
    chk("fl_occ2", occ1, 2);
    flush1 = 1; out_ready1 = 1; in_ctrl1 = 19'h13; in_data1 = 128'h213; cyc();
    flush1 = 0; in_valid1 = 0;
    chk("fl_occ", occ1, 0);
    chk("fl_valid", out_valid1, 0);
    chk("fl_ctrl", out_ctrl1, 0);
    chk("fl_data_hold", out_data1, 128'h211);

    // Flush from ONE with a concurrent accepted beat: the beat is discarded.
    out_ready1 = 0; in_valid1 = 1; in_ctrl1 = 19'h21; in_data1 = 128'h221; cyc();
    flush1 = 1; in_ctrl1 = 19'h22; in_data1 = 128'h222; cyc();
    flush1 = 0; in_valid1 = 0; cyc();
    chk("fl1_occ", occ1, 0);
    chk("fl1_ctrl", out_ctrl1, 0);

    // Mid-stream reset with both entries full takes effect before the next edge.
    in_valid1 = 1; in_ctrl1 = 19'h31; in_data1 = 128'h331; cyc();
    in_ctrl1 = 19'h32; in_data1 = 128'h332; cyc();
    in_valid1 = 0;
    chk("mr_occ2", occ1, 2);
    rst = 0; #1;
    chk("mr_valid", out_valid1, 0);
    chk("mr_occ", occ1, 0);
    chk("mr_ctrl", out_ctrl1, 0);
    chk("mr_data", out_data1, 0);
    chk("mr_in_ready", in_ready1, 1);
    cyc();
    rst = 1; cyc();

    // First beat after reset appears one edge later.
    in_valid1 = 1; in_ctrl1 = 19'h5; in_data1 = 128'h55; cyc();
    in_valid1 = 0;
    chk("lat_valid", out_valid1, 1);
    chk("lat_ctrl", out_ctrl1, 19'h5);
    out_ready1 = 1; cyc();

    // Streaming on both instances with random ready.
    dlv0 = 0; dlv1 = 0; occ0_max = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          int g; logic acc;
          in_valid1 = 1; in_ctrl1 = CW'($urandom);
          in_data1 = {$urandom, $urandom, $urandom, $urandom};
          g = 0; acc = 0;
          while (!acc && g < 200) begin
            @(negedge clk); acc = in_valid1 && in_ready1; cyc(); g++;
          end
          if (!acc) begin tot_cnt++; $display("FAIL stream1_timeout: beat %0d", i); end
          in_valid1 = 0;
          if ($urandom_range(0, 3) == 0) cyc();
        end
        done1 = 1;
      end
      begin
        while (!done1) begin out_ready1 = ($urandom_range(0, 1) == 1); cyc(); end
      end
      begin
        for (int i = 0; i < 100; i++) begin
          int g; logic acc;
          in_valid0 = 1; in_ctrl0 = CW'($urandom);
          in_data0 = {$urandom, $urandom, $urandom, $urandom};
          g = 0; acc = 0;
          while (!acc && g < 200) begin
            @(negedge clk); acc = in_valid0 && in_ready0; cyc(); g++;
          end
          if (!acc) begin tot_cnt++; $display("FAIL stream0_timeout: beat %0d", i); end
          in_valid0 = 0;
          if ($urandom_range(0, 3) == 0) cyc();
        end
        done0 = 1;
      end
      begin
        while (!done0) begin out_ready0 = ($urandom_range(0, 1) == 1); cyc(); end
      end
    join
    out_ready1 = 1; out_ready0 = 1;
    repeat (6) cyc();
    chk("st1_delivered", dlv1, 100);
    chk("st0_delivered", dlv0, 100);
    chk("st1_queue_empty", q1.size(), 0);
    chk("st0_queue_empty", q0.size(), 0);
    chk("st0_occ_le1", (occ0_max <= 2'd1), 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
